// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush scheduler for memory waits, load-use hazards and redirects.
module hazard_stall_ctrl #(
    parameter int CNT_W         = 16,
    parameter int REDIRECT_NOPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_index,
    input  logic [4:0]       id_rs2_index,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_index,
    input  logic             ex_regfile_en,
    input  logic             ex_is_load,
    input  logic             ex_jb_taken,
    input  logic             im_busy,
    input  logic             dm_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);
    localparam int NW = REDIRECT_NOPS > 1 ? $clog2(REDIRECT_NOPS) : 1;
    localparam logic [NW-1:0] NOP_INIT = NW'(REDIRECT_NOPS - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     nop_q, nop_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              mem_wait, load_use, redir;

    always_comb begin
        mem_wait = im_busy | dm_busy;
        load_use = ex_is_load & ex_regfile_en & (ex_rd_index != 5'd0) &
                   ((id_rs1_used & (id_rs1_index == ex_rd_index)) |
                    (id_rs2_used & (id_rs2_index == ex_rd_index)));
        // A MEM_WAIT cycle whose wait has cleared behaves as RUN so a pending redirect starts at once
        redir = (state_q != REDIRECT && (ex_jb_taken || pend_q)) || state_q == REDIRECT;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_d      = RUN;
        nop_d        = nop_q;
        pend_d       = pend_q;
        if (rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            pend_d       = pend_q | ex_jb_taken;
            state_d      = (state_q == REDIRECT) ? REDIRECT : MEM_WAIT;
        end else if (redir) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (state_q == REDIRECT) begin
                nop_d   = nop_q - NW'(1);
                state_d = (nop_q == NW'(1)) ? RUN : REDIRECT;
            end else begin
                nop_d   = NOP_INIT;
                pend_d  = 1'b0;
                state_d = (NOP_INIT != '0) ? REDIRECT : RUN;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            nop_q   <= '0;
            pend_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            nop_q   <= nop_d;
            pend_q  <= pend_d;
            if (pc_stall && !(&stall_q))
                stall_q <= stall_q + CNT_W'(1);
            if (id_ex_flush && !(&flush_q))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl with CNT_W=4, REDIRECT_NOPS=2.
module tb_hazard_stall_ctrl;
    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] RSTV = 6'b000011;
    localparam logic [5:0] LU   = 6'b110001;
    localparam logic [5:0] RD   = 6'b000011;
    localparam logic [5:0] MW   = 6'b111100;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1_index, id_rs2_index, ex_rd_index;
    logic id_rs1_used, id_rs2_used, ex_regfile_en, ex_is_load, ex_jb_taken, im_busy, dm_busy;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
    logic [3:0] stall_cycles, flush_cycles;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    logic [3:0] m_stall = 4'd0;
    logic [3:0] m_flush = 4'd0;

    hazard_stall_ctrl #(.CNT_W(4), .REDIRECT_NOPS(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_index(ex_rd_index), .ex_regfile_en(ex_regfile_en),
        .ex_is_load(ex_is_load), .ex_jb_taken(ex_jb_taken),
        .im_busy(im_busy), .dm_busy(dm_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [5:0] e, input string name);
        logic [5:0] got, w;
        exp_q.push_back(e);
        #3;
        got = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
        w = exp_q.pop_front();
        checks++;
        if (got !== w) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b at %0t", name, got, w, $time);
        end
        checks++;
        if (stall_cycles !== m_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d at %0t", name, stall_cycles, m_stall, $time);
        end
        checks++;
        if (flush_cycles !== m_flush) begin
            errors++;
            $display("FAIL %s flush_cycles: got %0d expected %0d at %0t", name, flush_cycles, m_flush, $time);
        end
        if (rst) begin
            m_stall = 4'd0;
            m_flush = 4'd0;
        end else begin
            if (e[5] && m_stall != 4'hF) m_stall++;
            if (e[0] && m_flush != 4'hF) m_flush++;
        end
        @(negedge clk);
    endtask

    task automatic set_lu(input logic on, input logic [4:0] rd);
        ex_is_load    = on;
        ex_regfile_en = on;
        ex_rd_index   = rd;
        id_rs2_index  = 5'd5;
        id_rs2_used   = on;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(RSTV, "reset0");
        cyc(RSTV, "reset1");
        rst = 1'b0;
        cyc(IDLE, "idle0");
        cyc(IDLE, "idle1");
    endtask

    task automatic test_load_use;
        set_lu(1'b1, 5'd5);
        cyc(LU, "lu_rs2");
        set_lu(1'b0, 5'd5);
        cyc(IDLE, "lu_after");
        set_lu(1'b1, 5'd0);
        cyc(IDLE, "lu_rd0");
        set_lu(1'b0, 5'd0);
        ex_is_load = 1'b1; ex_regfile_en = 1'b1; ex_rd_index = 5'd9;
        id_rs1_index = 5'd9; id_rs1_used = 1'b1;
        cyc(LU, "lu_rs1");
        id_rs1_used = 1'b0;
        cyc(IDLE, "lu_rs1_unused");
        ex_regfile_en = 1'b0; id_rs1_used = 1'b1;
        cyc(IDLE, "lu_no_wen");
        ex_is_load = 1'b0; id_rs1_used = 1'b0;
        cyc(IDLE, "lu_clear");
    endtask

    task automatic test_branch;
        ex_jb_taken = 1'b1;
        cyc(RD, "br0");
        ex_jb_taken = 1'b0;
        cyc(RD, "br1");
        cyc(IDLE, "br_end");
        set_lu(1'b1, 5'd5);
        ex_jb_taken = 1'b1;
        cyc(RD, "br_lu0");
        ex_jb_taken = 1'b0;
        cyc(RD, "br_lu1");
        set_lu(1'b0, 5'd5);
        cyc(IDLE, "br_lu_end");
    endtask

    task automatic test_dm_wait;
        dm_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc(MW, "dm_wait");
        dm_busy = 1'b0;
        cyc(IDLE, "dm_done");
    endtask

    task automatic test_branch_during_wait;
        im_busy = 1'b1; ex_jb_taken = 1'b1;
        cyc(MW, "bw_busy0");
        ex_jb_taken = 1'b0;
        cyc(MW, "bw_busy1");
        im_busy = 1'b0;
        cyc(RD, "bw_flush0");
        cyc(RD, "bw_flush1");
        cyc(IDLE, "bw_end");
    endtask

    task automatic test_wait_in_redirect;
        ex_jb_taken = 1'b1;
        cyc(RD, "wr_flush0");
        ex_jb_taken = 1'b0; dm_busy = 1'b1;
        cyc(MW, "wr_hold0");
        cyc(MW, "wr_hold1");
        dm_busy = 1'b0;
        cyc(RD, "wr_flush1");
        cyc(IDLE, "wr_end");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 20; i++) begin
            set_lu(1'b1, 5'd5);
            cyc(LU, "sat_lu");
            set_lu(1'b0, 5'd5);
            cyc(IDLE, "sat_gap");
        end
        checks++;
        if (stall_cycles !== 4'hF) begin
            errors++;
            $display("FAIL sat_final: got %0d expected 15", stall_cycles);
        end
    endtask

    task automatic test_mid_reset;
        ex_jb_taken = 1'b1;
        cyc(RD, "mr_redirect");
        ex_jb_taken = 1'b0; rst = 1'b1;
        cyc(RSTV, "mr_rst");
        rst = 1'b0;
        cyc(IDLE, "mr_run");
        im_busy = 1'b1; ex_jb_taken = 1'b1;
        cyc(MW, "mr_pend");
        im_busy = 1'b0; ex_jb_taken = 1'b0; rst = 1'b1;
        cyc(RSTV, "mr_rst2");
        rst = 1'b0;
        cyc(IDLE, "mr_dropped");
        cyc(IDLE, "mr_idle");
    endtask

    initial begin
        rst = 1'b1;
        id_rs1_index = 5'd0; id_rs2_index = 5'd0; ex_rd_index = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_regfile_en = 1'b0;
        ex_is_load = 1'b0; ex_jb_taken = 1'b0; im_busy = 1'b0; dm_busy = 1'b0;
        @(negedge clk);
        test_reset;
        test_load_use;
        test_branch;
        test_dm_wait;
        test_branch_during_wait;
        test_wait_in_redirect;
        test_saturation;
        test_mid_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32 pipeline.
- Drives the hold and bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers from three sources: memory wait handshakes, load-use hazards, and control redirects.
- Sits beside the ID/EX boundary. Combines ID-stage operand indices with EX-stage destination/branch info and IM/DM busy flags.
- Keeps saturating performance counters of stall and flush cycles.

Parameters:
- CNT_W, 16, width of the stall_cycles and flush_cycles counters.
- REDIRECT_NOPS, 2, number of consecutive cycles id_ex_flush and if_id_flush stay asserted per taken jump/branch (minimum 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_rs1_index  in  5  rs1 index of the instruction in ID
- id_rs2_index  in  5  rs2 index of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd_index  in  5  rd index of the instruction in EX
- ex_regfile_en  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load
- ex_jb_taken  in  1  EX resolved a taken jump/branch this cycle
- im_busy  in  1  instruction memory not ready
- dm_busy  in  1  data memory not ready
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  hold ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
- flush_cycles  out  CNT_W  saturating count of cycles with id_ex_flush=1

Behaviour:
Reset and FSM:
- Reset: state RUN, nop_cnt=0, redirect_pend=0, both counters 0.
- While rst=1, all stalls are 0 and if_id_flush = id_ex_flush = 1.
- FSM states: RUN, MEM_WAIT, REDIRECT. All outputs are combinational from state and inputs. State and counters are registered.

Priority per cycle, highest first:
1. mem_wait = im_busy | dm_busy.
   - All four stalls = 1, both flushes = 0.
   - If ex_jb_taken=1 in this cycle, set redirect_pend=1 so the redirect is not lost.
   - Next state: MEM_WAIT.
2. Redirect. Condition: (state RUN and (ex_jb_taken or redirect_pend)), or state REDIRECT.
   - if_id_flush = id_ex_flush = 1, all stalls = 0.
   - Entry from RUN: nop_cnt <= REDIRECT_NOPS-1 and redirect_pend cleared.
   - If nop_cnt is nonzero, go to REDIRECT. In REDIRECT, nop_cnt decrements each cycle and the FSM returns to RUN when it reaches 0.
   - With REDIRECT_NOPS=1, stay in RUN.
   - Redirect overrides load-use detection; no load-use stall is issued during redirect cycles.
3. Load-use. Condition: ex_is_load & ex_regfile_en & (ex_rd_index!=0) & ((id_rs1_used & rs1==rd) | (id_rs2_used & rs2==rd)).
   - pc_stall = if_id_stall = 1, id_ex_flush = 1 (bubble), id_ex_stall = ex_mem_stall = 0.
   - Lasts exactly one cycle, because the bubble clears the EX load.
4. Otherwise all outputs are 0.

State transitions:
- MEM_WAIT: leave when mem_wait=0. Go to RUN, where a pending redirect is then serviced immediately.
- mem_wait in REDIRECT: freeze nop_cnt and the state, and assert the stalls (priority 1).
- The REDIRECT state is resumed after the wait clears.

Counters:
- Increment by 1 on each qualifying cycle.
- Saturate at all-ones and never wrap.
- A simultaneous rst clears them.

Reset mid-operation:
- rst in any state returns to RUN with the reset output values.
- A pending redirect is dropped.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> flushes=1, stalls=0, counters 0. After release, all outputs 0.
- Load-use: ex_is_load=1, ex_regfile_en=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1, then 0. stall_cycles=1, flush_cycles=1. Repeat with ex_rd=0 -> no stall.
- Taken branch: ex_jb_taken pulse, REDIRECT_NOPS=2 -> id_ex_flush=if_id_flush=1 for exactly 2 cycles, stalls 0. With a simultaneous load-use match -> no stall, same 2 flush cycles.
- DM wait: dm_busy=1 for 3 cycles -> all four stalls 1 for 3 cycles, flushes 0, stall_cycles +3.
- Branch during wait: ex_jb_taken=1 with im_busy=1, im_busy held 2 cycles -> no flush while busy. Then 2 flush cycles start in the first cycle after im_busy falls.
- Saturation and mid-reset: CNT_W=4, 20 load-use events -> stall_cycles=15. rst asserted in REDIRECT -> next cycle RUN, counters 0.
